multicycle_chunk_adder: RTL and testbench

//  Parametrised multi-cycle ripple adder; successor to the 4-bit combinational ripple-carry adder.

---
 rtl/multicycle_chunk_adder.sv | 132 +++++++++++++
 tb/tb_multicycle_chunk_adder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_chunk_adder.sv
// Multi-cycle ripple adder: adds two WIDTH-bit operands plus carry-in, CHUNK bits
// per clock (LSB chunk first), with valid/ready handshakes on both sides.
module multicycle_chunk_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);
    localparam int unsigned NCHUNK   = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
    localparam int unsigned IDX_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned CSUM_W   = CHUNK + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
        $error("multicycle_chunk_adder: invalid WIDTH/CHUNK combination");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_r, a_d;
    logic [WIDTH-1:0]  b_r, b_d;
    logic              carry_r, carry_d;
    logic [IDX_W-1:0]  idx_r, idx_d;
    logic [WIDTH-1:0]  sum_d;
    logic              c_out_d;
    logic              overflow_d;
    logic              in_ready_d;
    logic              out_valid_d;

    logic [CHUNK-1:0]  a_chunk;
    logic [CHUNK-1:0]  b_chunk;
    logic [CSUM_W-1:0] chunk_sum;
    logic              msb_carry;
    int unsigned       base;

    // State register plus all registered datapath and handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            carry_r   <= 1'b0;
            idx_r     <= '0;
            sum       <= '0;
            c_out     <= 1'b0;
            overflow  <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_r       <= a_d;
            b_r       <= b_d;
            carry_r   <= carry_d;
            idx_r     <= idx_d;
            sum       <= sum_d;
            c_out     <= c_out_d;
            overflow  <= overflow_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
        end
    end

    // Next-state, chunk adder and next values of every register
    always_comb begin
        state_d     = state_q;
        a_d         = a_r;
        b_d         = b_r;
        carry_d     = carry_r;
        idx_d       = idx_r;
        sum_d       = sum;
        c_out_d     = c_out;
        overflow_d  = overflow;

        base        = 32'(idx_r) * CHUNK;
        a_chunk     = a_r[base +: CHUNK];
        b_chunk     = b_r[base +: CHUNK];
        chunk_sum   = {1'b0, a_chunk} + {1'b0, b_chunk} + CSUM_W'(carry_r);
        // Carry into the chunk's top bit recovered from its sum bit
        msb_carry   = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = c_in;
                    idx_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                sum_d[base +: CHUNK] = chunk_sum[CHUNK-1:0];
                carry_d              = chunk_sum[CHUNK];
                idx_d                = idx_r + IDX_W'(1);
                if (idx_r == LAST_IDX) begin
                    c_out_d    = chunk_sum[CHUNK];
                    overflow_d = msb_carry ^ chunk_sum[CHUNK];
                    idx_d      = '0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

endmodule

// File: tb/tb_multicycle_chunk_adder.sv
// Self-checking bench for multicycle_chunk_adder: directed vector table, handshake
// corner sequences, and randomized runs on CHUNK=4/1/16 builds against an arithmetic model.
module tb_multicycle_chunk_adder;
    localparam int W    = 16;
    localparam int NDUT = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;

    logic         in_ready_v  [NDUT];
    logic         out_valid_v [NDUT];
    logic         out_ready_v [NDUT];
    logic [W-1:0] sum_v       [NDUT];
    logic         c_out_v     [NDUT];
    logic         ovf_v       [NDUT];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    multicycle_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_c4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_v[0]),
        .a(a), .b(b), .c_in(c_in), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .sum(sum_v[0]), .c_out(c_out_v[0]), .overflow(ovf_v[0])
    );

    multicycle_chunk_adder #(.WIDTH(16), .CHUNK(1)) u_c1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_v[1]),
        .a(a), .b(b), .c_in(c_in), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .sum(sum_v[1]), .c_out(c_out_v[1]), .overflow(ovf_v[1])
    );

    multicycle_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_c16 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_v[2]),
        .a(a), .b(b), .c_in(c_in), .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
        .sum(sum_v[2]), .c_out(c_out_v[2]), .overflow(ovf_v[2])
    );

    function automatic int lat(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 16 : 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One full transaction on the CHUNK=4 instance with the consumer always ready
    task automatic run_vec(input vec_t v, input string tag);
        int k;
        check({tag, " in_ready"}, 32'(in_ready_v[0]), 32'd1);
        a = v.a; b = v.b; c_in = v.cin; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; a = ~v.a; b = W'($urandom); c_in = ~v.cin;
        k = 0;
        while (!out_valid_v[0] && k < 40) begin
            tick();
            k++;
        end
        check({tag, " latency"}, 32'(k), 32'd4);
        check({tag, " sum"}, 32'(sum_v[0]), 32'(v.s));
        check({tag, " c_out"}, 32'(c_out_v[0]), 32'(v.co));
        check({tag, " overflow"}, 32'(ovf_v[0]), 32'(v.ov));
        tick();
        check({tag, " idle out_valid"}, 32'(out_valid_v[0]), 32'd0);
        check({tag, " idle in_ready"}, 32'(in_ready_v[0]), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        vec_t v;
        logic [16:0] exp17;
        int s_int;
        logic exp_ov;
        logic done [NDUT];
        logic seen [NDUT];
        logic prev_valid [NDUT];
        logic prev_ready [NDUT];
        logic all_done;

        vecs[0] = '{16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h000A, 16'h0005, 1'b1, 16'h0010, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
        vecs[7] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};

        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0;
        for (int i = 0; i < NDUT; i++) out_ready_v[i] = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        check("reset in_ready", 32'(in_ready_v[0]), 32'd1);
        check("reset out_valid", 32'(out_valid_v[0]), 32'd0);
        check("reset sum", 32'(sum_v[0]), 32'd0);
        check("reset c_out", 32'(c_out_v[0]), 32'd0);
        check("reset overflow", 32'(ovf_v[0]), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: result held for 5 cycles while new operands are offered
        out_ready_v[0] = 1'b0;
        a = 16'h1357; b = 16'h2468; c_in = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid_v[0] && k < 40) begin
            tick();
            k++;
        end
        check("bp latency", 32'(k), 32'd4);
        for (int i = 0; i < 5; i++) begin
            a = W'($urandom); b = W'($urandom); c_in = 1'($urandom); in_valid = 1'b1;
            tick();
            check("bp out_valid", 32'(out_valid_v[0]), 32'd1);
            check("bp in_ready", 32'(in_ready_v[0]), 32'd0);
            check("bp sum", 32'(sum_v[0]), 32'h37BF);
            check("bp c_out", 32'(c_out_v[0]), 32'd0);
            check("bp overflow", 32'(ovf_v[0]), 32'd0);
        end
        in_valid = 1'b0;
        out_ready_v[0] = 1'b1;
        tick();
        check("bp release out_valid", 32'(out_valid_v[0]), 32'd0);
        check("bp release in_ready", 32'(in_ready_v[0]), 32'd1);

        // Reset two cycles into ADD discards the operation
        a = 16'hAAAA; b = 16'h5555; c_in = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst in_ready", 32'(in_ready_v[0]), 32'd1);
        check("rst out_valid", 32'(out_valid_v[0]), 32'd0);
        check("rst sum", 32'(sum_v[0]), 32'd0);
        check("rst c_out", 32'(c_out_v[0]), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rst no pulse", 32'(out_valid_v[0]), 32'd0);
        end
        v = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
        run_vec(v, "post-rst");

        // Randomized runs on all three builds with random consumer stalls
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int t = 0; t < 1000; t++) begin
            a = W'($urandom); b = W'($urandom); c_in = 1'($urandom_range(0, 1));
            exp17  = 17'(a) + 17'(b) + 17'(c_in);
            s_int  = int'($signed(a)) + int'($signed(b)) + int'(c_in);
            exp_ov = (s_int > 32767) || (s_int < -32768);
            for (int i = 0; i < NDUT; i++) begin
                done[i] = 1'b0; seen[i] = 1'b0; prev_valid[i] = 1'b0; prev_ready[i] = 1'b0;
            end
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0; a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
            k = 0;
            all_done = 1'b0;
            while (!all_done && k < 200) begin
                for (int i = 0; i < NDUT; i++) begin
                    out_ready_v[i] = 1'($urandom_range(0, 1));
                    prev_ready[i]  = out_ready_v[i];
                end
                tick();
                k++;
                all_done = 1'b1;
                for (int i = 0; i < NDUT; i++) begin
                    if (!done[i]) begin
                        if (prev_valid[i] && prev_ready[i]) begin
                            done[i] = 1'b1;
                        end else if (out_valid_v[i] && !seen[i]) begin
                            seen[i] = 1'b1;
                            check($sformatf("rand%0d dut%0d latency", t, i), 32'(k), 32'(lat(i)));
                            check($sformatf("rand%0d dut%0d {c_out,sum}", t, i),
                                  32'({c_out_v[i], sum_v[i]}), 32'(exp17));
                            check($sformatf("rand%0d dut%0d overflow", t, i), 32'(ovf_v[i]), 32'(exp_ov));
                            check($sformatf("rand%0d dut%0d ready/valid exclusive", t, i),
                                  32'(in_ready_v[i] & out_valid_v[i]), 32'd0);
                        end
                        prev_valid[i] = out_valid_v[i];
                    end
                    if (!done[i]) all_done = 1'b0;
                end
            end
            if (!all_done) begin
                check($sformatf("rand%0d completion", t), 32'd0, 32'd1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
